// File: rtl/miriscv_lsu_if.sv
// Bundle of the core-side and device-side load/store signals around the LSU.
// The slave view is the LSU itself; the master view is the core plus data bus.
interface miriscv_lsu_if;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_o;
   logic        lsu_err_o;
   logic        dev_req_o;
   logic        dev_we_o;
   logic [3:0]  dev_mask_o;
   logic [31:0] dev_addr_o;
   logic [31:0] dev_wr_data_o;
   logic [31:0] dev_rd_data_i;
   logic        dev_rvalid_i;

   modport slave (
      input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
      input  dev_rd_data_i, dev_rvalid_i,
      output lsu_data_o, lsu_stall_o, lsu_err_o,
      output dev_req_o, dev_we_o, dev_mask_o, dev_addr_o, dev_wr_data_o
   );

   modport master (
      output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
      output dev_rd_data_i, dev_rvalid_i,
      input  lsu_data_o, lsu_stall_o, lsu_err_o,
      input  dev_req_o, dev_we_o, dev_mask_o, dev_addr_o, dev_wr_data_o
   );
endinterface

// File: rtl/miriscv_lsu.sv
// Load/store unit: turns core byte-addressed accesses into word-aligned device
// requests with byte enables, and extends returning load data back to the core.
module miriscv_lsu #(
   parameter int TIMEOUT = 16
) (
   input logic          clk,
   input logic          reset,
   miriscv_lsu_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [1:0]  off_q;
   logic [2:0]  size_q;

   logic        size_ok;
   logic        misaligned;
   logic        access_ok;
   logic        timeout_hit;
   logic [3:0]  st_mask;
   logic [31:0] st_data;
   logic [31:0] shifted;
   logic [31:0] load_data;

   always_comb begin
      size_ok    = 1'b0;
      misaligned = 1'b0;
      case (bus.lsu_size_i)
         3'd0, 3'd4: size_ok = 1'b1;
         3'd1, 3'd5: begin
            size_ok    = 1'b1;
            misaligned = bus.lsu_addr_i[0];
         end
         3'd2: begin
            size_ok    = 1'b1;
            misaligned = |bus.lsu_addr_i[1:0];
         end
         default: ;
      endcase
   end

   assign access_ok   = size_ok && !misaligned;
   assign timeout_hit = (cnt_q == CNT_LAST);

   // Stores replicate the data across lanes so the device only needs the mask.
   always_comb begin
      st_mask = 4'b1111;
      st_data = bus.lsu_data_i;
      case (bus.lsu_size_i[1:0])
         2'd0: begin
            st_mask = 4'b0001 << bus.lsu_addr_i[1:0];
            st_data = {4{bus.lsu_data_i[7:0]}};
         end
         2'd1: begin
            st_mask = 4'b0011 << {bus.lsu_addr_i[1], 1'b0};
            st_data = {2{bus.lsu_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = bus.dev_rd_data_i >> {off_q, 3'b000};

   always_comb begin
      case (size_q)
         3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'd4:    load_data = {24'h0, shifted[7:0]};
         3'd5:    load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // Outputs are forced low for the whole time reset is held.
   always_comb begin
      bus.dev_req_o     = 1'b0;
      bus.dev_we_o      = 1'b0;
      bus.dev_mask_o    = 4'b0000;
      bus.dev_addr_o    = 32'h0;
      bus.dev_wr_data_o = 32'h0;
      bus.lsu_data_o    = 32'h0;
      bus.lsu_stall_o   = 1'b0;
      bus.lsu_err_o     = 1'b0;
      if (!reset) begin
         bus.dev_addr_o = {bus.lsu_addr_i[31:2], 2'b00};
         case (state_q)
            ST_IDLE: begin
               if (bus.lsu_req_i) begin
                  if (!access_ok) begin
                     bus.lsu_err_o = 1'b1;
                  end else begin
                     bus.dev_req_o = 1'b1;
                     bus.dev_we_o  = bus.lsu_we_i;
                     if (bus.lsu_we_i) begin
                        bus.dev_mask_o    = st_mask;
                        bus.dev_wr_data_o = st_data;
                     end else begin
                        bus.dev_mask_o  = 4'b1111;
                        bus.lsu_stall_o = 1'b1;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (bus.dev_rvalid_i) begin
                  bus.lsu_data_o = load_data;
               end else if (timeout_hit) begin
                  bus.lsu_err_o = 1'b1;
               end else begin
                  bus.lsu_stall_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Read data wins over the timeout when both land in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         off_q   <= 2'd0;
         size_q  <= 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.lsu_req_i && access_ok && !bus.lsu_we_i) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= 8'd0;
                  off_q   <= bus.lsu_addr_i[1:0];
                  size_q  <= bus.lsu_size_i;
               end
            end
            ST_WAIT: begin
               if (bus.dev_rvalid_i || timeout_hit) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Testbench for miriscv_lsu: directed and random accesses checked against a
// plain-arithmetic model of the load/store rules.
module tb_miriscv_lsu;

   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   miriscv_lsu_if bus ();

   miriscv_lsu #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [103:0] obs;
   logic [103:0] exp_v;

   assign obs = {bus.dev_req_o, bus.dev_we_o, bus.dev_mask_o, bus.lsu_stall_o, bus.lsu_err_o,
                 bus.dev_addr_o, bus.dev_wr_data_o, bus.lsu_data_o};

   function automatic bit m_legal(input logic [2:0] size, input logic [31:0] addr);
      case (size)
         3'd0, 3'd4: return 1'b1;
         3'd1, 3'd5: return (addr % 2) == 0;
         3'd2:       return (addr % 4) == 0;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] m_mask(input logic [2:0] size, input logic [31:0] addr);
      longint unsigned off = longint'(addr % 4);
      case (size)
         3'd0:    return 4'(64'd1 << off);
         3'd1:    return 4'(64'd3 << off);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
      longint unsigned dv = longint'(d);
      case (size)
         3'd0:    return 32'((dv % 256) * 64'h01010101);
         3'd1:    return 32'((dv % 65536) * 64'h00010001);
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                          input logic [31:0] rd);
      longint unsigned s = longint'(rd) / (64'd1 << (8 * (addr % 4)));
      longint          b = longint'(s % 256);
      longint          h = longint'(s % 65536);
      case (size)
         3'd0:    return 32'((b >= 128) ? b - 256 : b);
         3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] al(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic req, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] d);
      bus.lsu_req_i  = req;
      bus.lsu_we_i   = we;
      bus.lsu_size_i = size;
      bus.lsu_addr_i = addr;
      bus.lsu_data_i = d;
   endtask

   task automatic do_idle(input string tag);
      tick();
      drive(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
      bus.dev_rvalid_i  = 1'b1;
      bus.dev_rd_data_i = $urandom;
      #3;
      exp_v = {8'h00, al(bus.lsu_addr_i), 32'h0, 32'h0};
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("[TB] FAIL %s idle: got %h want %h", tag, obs, exp_v);
      end
   endtask

   task automatic do_store(input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] d, input string tag);
      tick();
      drive(1'b1, 1'b1, size, addr, d);
      bus.dev_rvalid_i = 1'b0;
      #3;
      exp_v = {1'b1, 1'b1, m_mask(size, addr), 1'b0, 1'b0, al(addr), m_wdata(size, d), 32'h0};
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("[TB] FAIL %s store: got %h want %h", tag, obs, exp_v);
      end
   endtask

   task automatic do_illegal(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input string tag);
      tick();
      drive(1'b1, we, size, addr, $urandom);
      bus.dev_rvalid_i = 1'b0;
      #3;
      exp_v = {8'b0000_0001, al(addr), 32'h0, 32'h0};
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("[TB] FAIL %s illegal: got %h want %h", tag, obs, exp_v);
      end
   endtask

   // lat = WAIT cycle carrying rvalid; anything above TIMEOUT means never.
   task automatic do_load(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] rd,
                          input int lat, input string tag, output int stalls);
      stalls = 0;
      tick();
      drive(1'b1, 1'b0, size, addr, $urandom);
      bus.dev_rvalid_i  = 1'b0;
      bus.dev_rd_data_i = $urandom;
      #3;
      if (bus.lsu_stall_o) stalls++;
      exp_v = {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, al(addr), 32'h0, 32'h0};
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("[TB] FAIL %s load req: got %h want %h", tag, obs, exp_v);
      end
      for (int c = 1; c <= TIMEOUT; c++) begin
         tick();
         bus.dev_rvalid_i  = (c == lat);
         bus.dev_rd_data_i = (c == lat) ? rd : $urandom;
         #3;
         if (bus.lsu_stall_o) stalls++;
         if (c == lat)
            exp_v = {8'h00, al(addr), 32'h0, m_load(size, addr, rd)};
         else if (c == TIMEOUT)
            exp_v = {8'b0000_0001, al(addr), 32'h0, 32'h0};
         else
            exp_v = {8'b0000_0010, al(addr), 32'h0, 32'h0};
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s load wait%0d: got %h want %h", tag, c, obs, exp_v);
         end
         if (c == lat || c == TIMEOUT) break;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 1'($urandom), 3'($urandom_range(0, 2)), $urandom, $urandom);
         bus.dev_rvalid_i  = 1'b1;
         bus.dev_rd_data_i = $urandom;
         #2;
         vectors++;
         if (obs !== 104'h0) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: got %h want 0", obs);
         end
      end
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      bus.dev_rvalid_i = 1'b0;
      do_idle("post_reset");
   endtask

   task automatic test_store();
      do_store(3'd0, 32'h0000_0103, 32'hAABB_CCDD, "sb_103");
      do_store(3'd1, 32'h0000_0202, 32'h0000_5678, "sh_202");
      do_store(3'd2, 32'h0000_0400, 32'hDEAD_BEEF, "sw_400");
      for (int i = 0; i < 8; i++)
         do_store(3'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFF0, $urandom, "st_rand");
   endtask

   task automatic test_load();
      int st;
      do_load(3'd0, 32'h0000_0102, 32'h0080_FF00, 1, "lb_102", st);
      vectors++;
      if (st !== 1) begin
         miscompares++;
         $display("[TB] FAIL lb stall cycles: got %0d want 1", st);
      end
      do_load(3'd4, 32'h0000_0102, 32'h0080_FF00, 1, "lbu_102", st);
      do_load(3'd1, 32'h0000_0202, 32'h8001_1234, 2, "lh_202", st);
      do_load(3'd5, 32'h0000_0202, 32'h8001_1234, 3, "lhu_202", st);
      do_load(3'd2, 32'h0000_0204, 32'h8765_4321, 1, "lw_204", st);
      do_idle("after_load");
   endtask

   task automatic test_illegal();
      do_illegal(1'b0, 3'd2, 32'h0000_0101, "lw_101");
      do_illegal(1'b0, 3'd3, 32'h0000_0100, "size3");
      do_illegal(1'b1, 3'd1, 32'h0000_0201, "sh_201");
      do_illegal(1'b0, 3'd5, 32'h0000_0303, "lhu_303");
      do_illegal(1'b1, 3'd7, 32'h0000_0000, "size7");
   endtask

   task automatic test_timeout();
      int st;
      do_load(3'd2, 32'h0000_0300, $urandom, TIMEOUT + 1, "lw_timeout", st);
      vectors++;
      if (st !== TIMEOUT) begin
         miscompares++;
         $display("[TB] FAIL timeout stall cycles: got %0d want %0d", st, TIMEOUT);
      end
      do_load(3'd2, 32'h0000_0300, 32'hCAFE_F00D, TIMEOUT, "lw_edge", st);
      do_load(3'd0, 32'h0000_0301, 32'h0000_7F00, TIMEOUT - 1, "lb_late", st);
   endtask

   task automatic test_reset_mid_wait();
      tick();
      drive(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
      bus.dev_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      bus.dev_rvalid_i  = 1'b1;
      bus.dev_rd_data_i = $urandom;
      #2;
      vectors++;
      if (obs !== 104'h0) begin
         miscompares++;
         $display("[TB] FAIL reset mid wait: got %h want 0", obs);
      end
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
      bus.dev_rvalid_i  = 1'b1;
      bus.dev_rd_data_i = 32'h1234_5678;
      #3;
      exp_v = {8'h00, 32'h0000_0040, 32'h0, 32'h0};
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("[TB] FAIL late rvalid after reset: got %h want %h", obs, exp_v);
      end
      do_store(3'd2, 32'h0000_0080, 32'h0BAD_F00D, "sw_80");
   endtask

   task automatic test_back_to_back();
      int st;
      do_load(3'd1, 32'h0000_0502, 32'hFFFF_0001, 1, "b2b_lh", st);
      do_store(3'd0, 32'h0000_0501, 32'h0000_00A5, "b2b_sb");
      do_load(3'd0, 32'h0000_0503, 32'h8000_0000, 2, "b2b_lb", st);
      do_illegal(1'b0, 3'd2, 32'h0000_0502, "b2b_bad");
      do_load(3'd4, 32'h0000_0503, 32'hF000_0000, 1, "b2b_lbu", st);
   endtask

   task automatic test_random();
      int st;
      logic [2:0]  size;
      logic [31:0] addr;
      for (int i = 0; i < 150; i++) begin
         size = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 5) == 0)
            do_idle("rand");
         else if (!m_legal(size, addr))
            do_illegal(1'($urandom), size, addr, "rand");
         else if ($urandom_range(0, 1) == 1 && size[2] == 1'b0)
            do_store(size, addr, $urandom, "rand");
         else
            do_load(size, addr, $urandom, $urandom_range(1, 6), "rand", st);
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      bus.dev_rvalid_i  = 1'b0;
      bus.dev_rd_data_i = 32'h0;
      test_reset();
      test_store();
      test_load();
      test_illegal();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/miriscv_lsu.md
# miriscv_lsu

Load/store unit sitting between the core's execute stage and the data-side address decoder. Converts core load/store requests (RISC-V `funct3` size codes, byte address) into word-aligned device requests with a byte-enable mask and lane-replicated write data. Returns sign- or zero-extended load data, and stalls the core while a load is outstanding. Flags misaligned and illegal-size accesses and unanswered loads (timeout) to the core.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum WAIT cycles before a load is aborted; range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `lsu_req_i`  in  1  core access request; held until the cycle `lsu_stall_o`=0.
- `lsu_we_i`  in  1  1=store, 0=load.
- `lsu_size_i`  in  3  `funct3`: 0 B, 1 H, 2 W, 4 BU, 5 HU; other codes are illegal.
- `lsu_addr_i`  in  32  byte address.
- `lsu_data_i`  in  32  store data; low bits are used.
- `lsu_data_o`  out  32  extended load data; valid when a load completes.
- `lsu_stall_o`  out  1  core must hold its request.
- `lsu_err_o`  out  1  one-cycle error pulse, valid on the completion cycle.
- `dev_req_o`  out  1  device request, one cycle per access.
- `dev_we_o`  out  1  device write enable.
- `dev_mask_o`  out  4  byte enables.
- `dev_addr_o`  out  32  `{lsu_addr_i[31:2],2'b00}`.
- `dev_wr_data_o`  out  32  lane-replicated store data.
- `dev_rd_data_i`  in  32  device read data.
- `dev_rvalid_i`  in  1  read data valid, at least 1 cycle after `dev_req_o`.

## Operation
- FSM has two states: IDLE and WAIT. Reset state is IDLE, with the timeout counter at 0 and the offset/size registers at 0.
- Alignment check: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0, is misaligned.
- IDLE with `lsu_req_i`=0: `dev_req_o`=0 and `lsu_stall_o`=0.
- IDLE, request is illegal-size or misaligned:
  - `lsu_err_o`=1 and `lsu_stall_o`=0 in the same cycle.
  - `dev_req_o`=0; no bus access.
  - State stays IDLE.
- IDLE, legal store:
  - `dev_req_o`=1 and `dev_we_o`=1, combinationally in the same cycle; `lsu_stall_o`=0 (posted write).
  - State stays IDLE.
- IDLE, legal load:
  - `dev_req_o`=1, `dev_we_o`=0, `lsu_stall_o`=1.
  - Register `addr[1:0]` and size, clear the counter, go to WAIT.
- WAIT:
  - `dev_req_o`=0.
  - If `dev_rvalid_i`=1: `lsu_data_o` is the extracted data, `lsu_stall_o`=0, go to IDLE.
  - Otherwise `lsu_stall_o`=1 and the counter increments.
  - When counter = `TIMEOUT`-1 with no `rvalid`: `lsu_data_o`=0, `lsu_err_o`=1, `lsu_stall_o`=0, go to IDLE.
- Store mask and data:
  - B: mask `4'b0001<<addr[1:0]`, data `{4{d[7:0]}}`.
  - H: mask `4'b0011<<{addr[1],1'b0}`, data `{2{d[15:0]}}`.
  - W: mask `4'b1111`, data `d`.
- Loads drive `dev_mask_o`=`4'b1111`.
- Load extract: shift `rd_data` right by 8×offset, then take the low 8 or 16 bits.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- `lsu_data_o`=0 whenever no load is completing.
- `dev_rvalid_i` in IDLE is ignored.

## Timing
- While `reset`=1, all outputs are 0 regardless of the inputs.
- Reset asserted in WAIT aborts the load. After release: IDLE, no error pulse, and a late `rvalid` is ignored.
- Store: 1 cycle, zero stall.
- Load: minimum 2 cycles (request cycle, then WAIT cycle with `rvalid`), i.e. 1 stall cycle.
- Load latency is 1 + N cycles for `rvalid` in WAIT cycle N.
- Timeout completes in WAIT cycle `TIMEOUT`.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after completion.
- `rvalid` arriving in the same cycle as the timeout: data wins, `lsu_err_o`=0.
- `dev_*` outputs are combinational from IDLE state and `lsu_*` inputs. `lsu_data_o` is combinational from `dev_rd_data_i` in WAIT.

## Test plan
- SB at `0x103` with data `0xAABBCCDD` -> same cycle: `dev_req_o`=1, `we`=1, mask `4'b1000`, addr `0x100`, wdata `0xDDDDDDDD`, stall 0.
- LB at `0x102`, `rd_data`=`0x0080FF00`, `rvalid` one cycle later -> `lsu_data_o`=`0xFFFFFF80`, stall high 1 cycle. Repeat as LBU -> `0x00000080`.
- LH at `0x202`, `rd_data`=`0x8001_1234` -> `0xFFFF8001`. LHU -> `0x00008001`. SH at `0x202`, data `0x5678` -> mask `4'b1100`, wdata `0x56785678`.
- LW at `0x101`, or size 3 -> `lsu_err_o`=1 in the same cycle, `dev_req_o`=0, stall 0.
- LW with `rvalid` never asserted, `TIMEOUT`=16 -> stall for 16 cycles, then `err`=1 and data 0 on the 17th cycle. Second run with `rvalid` exactly on the timeout cycle -> data returned, `err`=0.
- LW enters WAIT, `reset` pulsed mid-WAIT, `rvalid` asserted after release -> all outputs 0 during reset, IDLE after release, no completion and no `err`. A following SW at `0x80` issues normally.
